id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between Instruction Decode and Execute in the 32-bit MIPS pipeline.
- Decodes opcode/funct into the ALU control bundle consumed by the 32-bit ALU (2-bit op, Binv) and selects operand B (register or sign-extended immediate).
- Registers the datapath and control fields one cycle, with stall (hold) and flush (bubble) support from the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset or bubble.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all EX-side registers this cycle.
- flush  in  1  load a bubble this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_opcode  in  6  instruction [31:26].
- id_funct  in  6  instruction [5:0].
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- id_rs_data, id_rt_data  in  32 each  register-file read data.
- id_imm  in  16  instruction [15:0].
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  32  registered PC.
- ex_a  out  32  ALU operand A, equal to rs_data.
- ex_b  out  32  ALU operand B: rt_data, or sign-extended imm.
- ex_store_data  out  32  rt_data, used by sw.
- ex_alu_op  out  2  00 AND, 01 OR, 10 ADD/SUB, 11 SLT.
- ex_binv  out  1  B-invert / carry-in for SUB, SLT and BEQ.
- ex_dst  out  5  destination register.
- ex_rs, ex_rt  out  5 each  source specifiers for the forwarding unit.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  control bits.
- ex_illegal  out  1  one-cycle flag: the instruction was unsupported and has been converted to a bubble.

Behaviour:
- Reset (async, rst=1): all outputs 0, except ex_pc=RESET_PC. Takes effect immediately, with no clock edge needed. The same applies to reset asserted mid-stall.
- Per-edge priority is rst > flush > stall > load.
  - flush=1: bubble, regardless of stall.
  - stall=1 without flush: every output holds its value. This includes ex_illegal, which therefore stays high if stall is asserted while it is set.
  - Otherwise: load from the ID inputs.
- Latency: one cycle. ID inputs at edge N appear on ex_* after edge N.
- Bubble: ex_valid=0, all control bits 0, ex_alu_op=00, ex_binv=0, data fields 0, ex_pc=RESET_PC, ex_illegal=0.
- Load with id_valid=0: loaded as a bubble.
- Decode (id_valid=1):
  - R-type (opcode 00): destination rd, B from register. By funct:
    - 20 ADD: op 10, binv 0.
    - 22 SUB: op 10, binv 1.
    - 24 AND: op 00.
    - 25 OR: op 01.
    - 2A SLT: op 11, binv 1.
    - All five set reg_write=1.
  - addi (08): op 10, binv 0, B=imm, destination rt, reg_write=1.
  - lw (23): op 10, B=imm, destination rt, reg_write=1, mem_read=1, mem_to_reg=1.
  - sw (2B): op 10, B=imm, mem_write=1, ex_dst=0.
  - beq (04): op 10, binv 1, B=rt_data, branch=1, ex_dst=0.
  - Any other opcode/funct: load a bubble and set ex_illegal=1 for that cycle only.
- Sign-extension: ex_b = {{16{imm[15]}}, imm}.
- Destination $0: if the decoded destination is 0, force ex_reg_write=0. ex_dst stays 0.
- Internal state: registers only. There is no FSM beyond load/hold/bubble.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ.
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - ALU op constants ALU_AND=00, ALU_OR=01, ALU_ADD=10, ALU_SLT=11.
  - a packed ex_ctrl_t struct holding all control bits.
- One combinational sub-module, alu_ctrl_decode, maps opcode/funct to ex_ctrl_t plus an illegal flag. It is reused by the verification model.

Test Plan:
- Reset mid-operation: rst pulsed between edges -> outputs immediately 0 and ex_pc=RESET_PC. After release, the next edge loads ADD r3,r1,r2 (rs_data=5, rt_data=7) -> alu_op=10, binv=0, ex_a=5, ex_b=7, dst=3, reg_write=1.
- Immediate path: addi r4,r1,-2 (imm=16'hFFFE) -> ex_b=32'hFFFF_FFFE, dst=4, binv=0. Then lw r5,8(r1) -> mem_read=1, mem_to_reg=1, ex_b=8.
- Branch/compare and store: SLT -> op=11, binv=1. beq -> op=10, binv=1, branch=1, reg_write=0. sw -> mem_write=1, ex_store_data=rt_data.
- Stall: assert stall for 3 cycles while ID changes -> ex_* unchanged. On release -> the new ID instruction appears after one edge.
- Simultaneous stall=1 and flush=1 -> bubble (ex_valid=0, all controls 0).
- Illegal and $0 destination: opcode 3F -> ex_valid=0 and ex_illegal=1 for one cycle. ADD r0,r1,r2 -> ex_valid=1, reg_write=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// - Opcode / funct encodings for the supported subset (R-type ADD/SUB/AND/OR/SLT, addi, lw, sw, beq).
// - ALU op encodings consumed by the 32-bit ALU (2-bit op plus Binv).
// - ex_ctrl_t: the decoded control bundle produced by alu_ctrl_decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  // Which instruction field names the destination register.
  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_RT   = 2'b01,
    DST_RD   = 2'b10
  } dst_sel_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       binv;
    logic       b_imm;      // operand B from sign-extended immediate
    dst_sel_t   dst_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_NOP = '0;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder for the ID/EX stage.
// Ports:
//   opcode, funct : instruction [31:26] and [5:0]
//   ctrl          : decoded control bundle (CTRL_NOP when illegal)
//   illegal       : opcode/funct pair is outside the supported subset
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ex_ctrl_t   ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.dst_sel   = DST_RD;
        ctrl.reg_write = 1'b1;
        unique case (funct)
          F_ADD: ctrl.alu_op = ALU_ADD;
          F_SUB: begin ctrl.alu_op = ALU_ADD; ctrl.binv = 1'b1; end
          F_AND: ctrl.alu_op = ALU_AND;
          F_OR:  ctrl.alu_op = ALU_OR;
          F_SLT: begin ctrl.alu_op = ALU_SLT; ctrl.binv = 1'b1; end
          default: begin ctrl = CTRL_NOP; illegal = 1'b1; end
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.b_imm     = 1'b1;
        ctrl.dst_sel   = DST_RT;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.b_imm      = 1'b1;
        ctrl.dst_sel    = DST_RT;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.b_imm     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_ADD;
        ctrl.binv   = 1'b1;
        ctrl.branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit MIPS pipeline.
// Decodes opcode/funct into ALU control, selects operand B, and registers
// datapath + control one cycle. Priority per edge: rst > flush > stall > load.
// Ports:
//   clk, rst               : clock, async active-high reset
//   stall, flush           : hazard-unit hold / bubble requests
//   id_*                   : decoded ID-stage instruction fields and register data
//   ex_valid, ex_pc        : EX instruction valid and PC
//   ex_a, ex_b             : ALU operands
//   ex_store_data          : rt data for sw
//   ex_alu_op, ex_binv     : ALU control
//   ex_dst, ex_rs, ex_rt   : register specifiers
//   ex_reg_write .. branch : control bits
//   ex_illegal             : unsupported instruction was squashed into a bubble
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [5:0]      id_opcode,
  input  logic [5:0]      id_funct,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [15:0]     id_imm,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [1:0]      ex_alu_op,
  output logic            ex_binv,
  output logic [4:0]      ex_dst,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [1:0]      alu_op;
    logic            binv;
    logic [4:0]      dst;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            illegal;
  } ex_reg_t;

  function automatic ex_reg_t bubble();
    ex_reg_t r;
    r    = '0;
    r.pc = RESET_PC;
    return r;
  endfunction

  ex_ctrl_t ctrl;
  logic     illegal;
  ex_reg_t  q, d;
  logic [4:0] dst;

  alu_ctrl_decode u_dec (
    .opcode  (id_opcode),
    .funct   (id_funct),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  always_comb begin
    unique case (ctrl.dst_sel)
      DST_RD:  dst = id_rd;
      DST_RT:  dst = id_rt;
      default: dst = 5'd0;
    endcase
  end

  // Next-state for a non-stalled edge; flush and invalid/illegal ID both bubble.
  always_comb begin
    d = bubble();
    if (!flush && id_valid) begin
      if (illegal) begin
        d.illegal = 1'b1;
      end else begin
        d.valid      = 1'b1;
        d.pc         = id_pc;
        d.a          = id_rs_data;
        d.b          = ctrl.b_imm ? sext16(id_imm) : id_rt_data;
        d.store_data = id_rt_data;
        d.alu_op     = ctrl.alu_op;
        d.binv       = ctrl.binv;
        d.dst        = dst;
        d.rs         = id_rs;
        d.rt         = id_rt;
        // Writes to $0 are architecturally discarded; drop them here.
        d.reg_write  = ctrl.reg_write && (dst != 5'd0);
        d.mem_read   = ctrl.mem_read;
        d.mem_write  = ctrl.mem_write;
        d.mem_to_reg = ctrl.mem_to_reg;
        d.branch     = ctrl.branch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 q <= bubble();
    else if (flush || !stall) q <= d;
  end

  assign ex_valid      = q.valid;
  assign ex_pc         = q.pc;
  assign ex_a          = q.a;
  assign ex_b          = q.b;
  assign ex_store_data = q.store_data;
  assign ex_alu_op     = q.alu_op;
  assign ex_binv       = q.binv;
  assign ex_dst        = q.dst;
  assign ex_rs         = q.rs;
  assign ex_rt         = q.rt;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_branch     = q.branch;
  assign ex_illegal    = q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// ctl vector layout: {valid, alu_op[1:0], binv, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal}
module tb_id_ex_stage;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0;
  logic [5:0]  id_opcode = '0, id_funct = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [15:0] id_imm = '0;

  logic        ex_valid, ex_binv, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_branch, ex_illegal;
  logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_dst, ex_rs, ex_rt;
  logic [9:0]  ctl;

  int checks = 0, errors = 0;

  id_ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_binv(ex_binv),
    .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {ex_valid, ex_alu_op, ex_binv, ex_reg_write, ex_mem_read,
                ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [15:0] imm, input logic [31:0] pc);
    id_valid = 1'b1; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++; if (ctl !== 10'b0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 10'b0); end
    checks++; if (ex_pc !== RPC) begin errors++; $display("FAIL reset_pc got %h exp %h", ex_pc, RPC); end
    rst = 1'b0;
    // load lw, then pulse reset between edges
    set_id(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 32'd100, 32'd0, 16'd4, 32'h40);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", ex_valid); end
    #2 rst = 1'b1; #1;
    checks++; if (ctl !== 10'b0 || ex_a !== 32'd0 || ex_b !== 32'd0 || ex_dst !== 5'd0)
      begin errors++; $display("FAIL mid_reset got ctl=%b a=%h b=%h dst=%0d exp zeros", ctl, ex_a, ex_b, ex_dst); end
    checks++; if (ex_pc !== RPC) begin errors++; $display("FAIL mid_reset_pc got %h exp %h", ex_pc, RPC); end
    rst = 1'b0;
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h1820, 32'h44);
    tick();
    checks++; if (ctl !== 10'b1_10_0_1_0_0_0_0_0) begin errors++; $display("FAIL add_ctl got %b exp %b", ctl, 10'b1_10_0_1_0_0_0_0_0); end
    checks++; if (ex_a !== 32'd5 || ex_b !== 32'd7 || ex_dst !== 5'd3 || ex_pc !== 32'h44)
      begin errors++; $display("FAIL add_data got a=%0d b=%0d dst=%0d pc=%h exp 5 7 3 44", ex_a, ex_b, ex_dst, ex_pc); end
    checks++; if (ex_rs !== 5'd1 || ex_rt !== 5'd2) begin errors++; $display("FAIL add_rsrt got %0d %0d exp 1 2", ex_rs, ex_rt); end
  endtask

  task automatic test_immediate();
    set_id(6'h08, 6'h3E, 5'd1, 5'd4, 5'd31, 32'd10, 32'd99, 16'hFFFE, 32'h48);
    tick();
    checks++; if (ctl !== 10'b1_10_0_1_0_0_0_0_0) begin errors++; $display("FAIL addi_ctl got %b exp %b", ctl, 10'b1_10_0_1_0_0_0_0_0); end
    checks++; if (ex_b !== 32'hFFFF_FFFE || ex_dst !== 5'd4 || ex_a !== 32'd10)
      begin errors++; $display("FAIL addi_data got b=%h dst=%0d a=%0d exp fffffffe 4 10", ex_b, ex_dst, ex_a); end
    set_id(6'h23, 6'h08, 5'd1, 5'd5, 5'd0, 32'd10, 32'd3, 16'd8, 32'h4C);
    tick();
    checks++; if (ctl !== 10'b1_10_0_1_1_0_1_0_0) begin errors++; $display("FAIL lw_ctl got %b exp %b", ctl, 10'b1_10_0_1_1_0_1_0_0); end
    checks++; if (ex_b !== 32'd8 || ex_dst !== 5'd5) begin errors++; $display("FAIL lw_data got b=%h dst=%0d exp 8 5", ex_b, ex_dst); end
  endtask

  task automatic test_branch_store();
    set_id(6'h00, 6'h2A, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, 16'h302A, 32'h50);
    tick();
    checks++; if (ctl !== 10'b1_11_1_1_0_0_0_0_0 || ex_dst !== 5'd6)
      begin errors++; $display("FAIL slt got ctl=%b dst=%0d exp %b 6", ctl, ex_dst, 10'b1_11_1_1_0_0_0_0_0); end
    set_id(6'h04, 6'h04, 5'd1, 5'd2, 5'd0, 32'd11, 32'hCAFE_0001, 16'h0004, 32'h54);
    tick();
    checks++; if (ctl !== 10'b1_10_1_0_0_0_0_1_0) begin errors++; $display("FAIL beq_ctl got %b exp %b", ctl, 10'b1_10_1_0_0_0_0_1_0); end
    checks++; if (ex_b !== 32'hCAFE_0001 || ex_dst !== 5'd0) begin errors++; $display("FAIL beq_data got b=%h dst=%0d exp cafe0001 0", ex_b, ex_dst); end
    set_id(6'h2B, 6'h0C, 5'd1, 5'd2, 5'd0, 32'd20, 32'hDEAD_BEEF, 16'd12, 32'h58);
    tick();
    checks++; if (ctl !== 10'b1_10_0_0_0_1_0_0_0) begin errors++; $display("FAIL sw_ctl got %b exp %b", ctl, 10'b1_10_0_0_0_1_0_0_0); end
    checks++; if (ex_store_data !== 32'hDEAD_BEEF || ex_b !== 32'd12 || ex_dst !== 5'd0)
      begin errors++; $display("FAIL sw_data got sd=%h b=%h dst=%0d exp deadbeef c 0", ex_store_data, ex_b, ex_dst); end
    set_id(6'h00, 6'h22, 5'd1, 5'd2, 5'd8, 32'd9, 32'd4, 16'h4022, 32'h5C);
    tick();
    checks++; if (ctl !== 10'b1_10_1_1_0_0_0_0_0) begin errors++; $display("FAIL sub_ctl got %b exp %b", ctl, 10'b1_10_1_1_0_0_0_0_0); end
  endtask

  task automatic test_stall();
    set_id(6'h00, 6'h24, 5'd3, 5'd4, 5'd7, 32'h0F0F, 32'h00FF, 16'h3824, 32'h60);
    tick();
    checks++; if (ctl !== 10'b1_00_0_1_0_0_0_0_0 || ex_dst !== 5'd7)
      begin errors++; $display("FAIL and got ctl=%b dst=%0d exp %b 7", ctl, ex_dst, 10'b1_00_0_1_0_0_0_0_0); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(6'h00, 6'h25, 5'd5, 5'd6, 5'(9 + i), 32'h1000 + i, 32'h2000, 16'h0025, 32'h64);
      tick();
      checks++; if (ctl !== 10'b1_00_0_1_0_0_0_0_0 || ex_dst !== 5'd7 || ex_a !== 32'h0F0F || ex_pc !== 32'h60)
        begin errors++; $display("FAIL stall_hold%0d got ctl=%b dst=%0d a=%h pc=%h", i, ctl, ex_dst, ex_a, ex_pc); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ctl !== 10'b1_01_0_1_0_0_0_0_0 || ex_dst !== 5'd11 || ex_a !== 32'h1002)
      begin errors++; $display("FAIL stall_release got ctl=%b dst=%0d a=%h exp %b 11 1002", ctl, ex_dst, ex_a, 10'b1_01_0_1_0_0_0_0_0); end
    // reset asserted while stalled still clears immediately
    stall = 1'b1; #2 rst = 1'b1; #1;
    checks++; if (ctl !== 10'b0 || ex_pc !== RPC || ex_a !== 32'd0)
      begin errors++; $display("FAIL stall_reset got ctl=%b pc=%h a=%h", ctl, ex_pc, ex_a); end
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_stall_flush();
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 32'h70);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_flush_valid got %b exp 1", ex_valid); end
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++; if (ctl !== 10'b0 || ex_pc !== RPC || ex_a !== 32'd0 || ex_b !== 32'd0 || ex_dst !== 5'd0)
      begin errors++; $display("FAIL stall_flush got ctl=%b pc=%h a=%h b=%h dst=%0d", ctl, ex_pc, ex_a, ex_b, ex_dst); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal();
    set_id(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h1, 32'h80);
    tick();
    checks++; if (ctl !== 10'b0_00_0_0_0_0_0_0_1 || ex_pc !== RPC)
      begin errors++; $display("FAIL illegal_op got ctl=%b pc=%h exp %b", ctl, ex_pc, 10'b0_00_0_0_0_0_0_0_1); end
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 16'h0020, 32'h84);
    tick();
    checks++; if (ctl !== 10'b1_10_0_0_0_0_0_0_0 || ex_dst !== 5'd0)
      begin errors++; $display("FAIL add_r0 got ctl=%b dst=%0d exp %b 0", ctl, ex_dst, 10'b1_10_0_0_0_0_0_0_0); end
    // bad funct, then stall holds the flag
    set_id(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 32'h88);
    tick();
    checks++; if (ctl !== 10'b0_00_0_0_0_0_0_0_1) begin errors++; $display("FAIL illegal_funct got %b exp %b", ctl, 10'b0_00_0_0_0_0_0_0_1); end
    stall = 1'b1;
    tick();
    checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL illegal_hold got %b exp 1", ex_illegal); end
    stall = 1'b0;
    id_valid = 1'b0;
    tick();
    checks++; if (ctl !== 10'b0 || ex_pc !== RPC) begin errors++; $display("FAIL invalid_bubble got ctl=%b pc=%h", ctl, ex_pc); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_branch_store();
    test_stall();
    test_stall_flush();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
